mem_line_requester: RTL and testbench
=====================================

Name: mem_line_requester

Overview:
- Initiator-side controller for the 128-bit line RAM port (data_requested / where_to_write / data_to_write / write_to_mem / data_returned).
- Sits between the cache miss logic and the line memory.
- Accepts one miss at a time. If the victim is dirty, it writes the victim back first, then fills the requested line.
- Models a fixed memory access latency and returns the filled line to the cache with a one-cycle valid pulse.

Parameters:
- LATENCY, 5, cycles per memory access (write-back or fill); legal range 1..255
- ADDR_W, 26, line address width
- LINE_W, 128, line data width

Ports:
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  miss request present
- req_ready  output  1  controller can accept a request
- req_line_addr  input  ADDR_W  line address to fill
- req_dirty  input  1  victim line must be written back
- req_victim_addr  input  ADDR_W  victim line address
- req_victim_data  input  LINE_W  victim line data
- resp_valid  output  1  one-cycle pulse; fill data valid
- resp_data  output  LINE_W  filled line
- resp_line_addr  output  ADDR_W  address of the filled line
- busy  output  1  state != IDLE
- data_requested  output  ADDR_W  fill line address to RAM
- where_to_write  output  ADDR_W  write-back line address to RAM
- data_to_write  output  LINE_W  write-back data to RAM
- write_to_mem  output  1  RAM write strobe
- data_returned  input  LINE_W  combinational read data from RAM

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state = IDLE; every output register = 0; req_ready = 1 (combinational from IDLE).
- FSM states: IDLE, WB, FILL, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid at a rising edge, capture req_line_addr, req_dirty, req_victim_addr and req_victim_data into registers.
  - Load lat_cnt = LATENCY-1.
  - Go to WB if req_dirty, else FILL.
- WB:
  - where_to_write and data_to_write driven from the captured registers for the whole state.
  - lat_cnt decrements each cycle.
  - In the cycle lat_cnt == 0: write_to_mem = 1 for exactly that one cycle; reload lat_cnt = LATENCY-1; go to FILL.
- FILL:
  - data_requested driven from the captured fill address for the whole state.
  - In the cycle lat_cnt == 0: register data_returned into resp_data and the address into resp_line_addr; go to RESP.
- RESP: resp_valid = 1 for exactly one cycle, then go to IDLE.
- Latency (accept at edge T):
  - Clean miss: resp_valid high in cycle T+LATENCY+1.
  - Dirty miss: write_to_mem high in cycle T+LATENCY; resp_valid high in cycle T+2*LATENCY+1.
- Request gating: req_ready = 0 in WB, FILL and RESP. req_valid is ignored there and must be held by the requester. The next accept is earliest in the cycle after RESP.
- Output holding: data_requested, where_to_write and data_to_write hold their last values outside their active states; they are not cleared. write_to_mem is 0 in every state other than the last WB cycle.
- resp_data and resp_line_addr hold their values until the next capture.
- Victim address equal to fill address: the write-back completes before the fill samples, so resp_data equals req_victim_data.
- LATENCY = 1: WB and FILL each last one cycle; write_to_mem and the fill capture happen in those single cycles.
- Reset mid-operation: reset_n low forces IDLE immediately. write_to_mem and resp_valid drop asynchronously. The in-flight request is discarded and no response follows the release of reset.
- lat_cnt width: 8 bits; no wrap occurs because it is reloaded before every decrement from 0.

Optional Feature:
- Macro: MEM_REQ_STATS_EN.
- Defined:
  - Adds outputs fill_count[15:0] and wb_count[15:0].
  - Each increments by 1 on the cycle its access completes (FILL lat_cnt == 0, WB write pulse).
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset check: reset_n low then high → resp_valid = 0, write_to_mem = 0, busy = 0, req_ready = 1; all address/data outputs = 0.
- Clean miss (LATENCY = 5): RAM line 0x0000400 preloaded with 128'h0123..CDEF; accept at cycle T → data_requested = 0x0000400 in T+1..T+5; resp_valid only in T+6; resp_data = 128'h0123..CDEF; write_to_mem never asserted.
- Dirty miss: victim 0x0002000 with data 128'hDEADBEEF_x4; fill 0x0002001 → write_to_mem high only in T+5 with where_to_write = 0x0002000; resp_valid in T+11; RAM line 0x2000 then reads DEADBEEF_x4.
- Victim address equals fill address = 0x0000010, victim data 128'hA5A5..A5 → resp_data = 128'hA5A5..A5.
- Back-to-back: req_valid held high with two requests → second request not accepted until IDLE (cycle after its first resp_valid); req_ready = 0 throughout busy.
- Reset in FILL cycle T+3 → resp_valid and write_to_mem 0 immediately; no resp_valid within 20 cycles after release; req_ready = 1.

Source files
------------

// File: rtl/mem_line_requester.sv
// Miss-side controller for the 128-bit line RAM: optional dirty-victim write-back, then fill, then a one-cycle response.
// Define MEM_REQ_STATS_EN to add saturating fill_count / wb_count outputs.
module mem_line_requester #(
  parameter int LATENCY = 5,
  parameter int ADDR_W  = 26,
  parameter int LINE_W  = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_line_addr,
  input  logic              req_dirty,
  input  logic [ADDR_W-1:0] req_victim_addr,
  input  logic [LINE_W-1:0] req_victim_data,
  output logic              resp_valid,
  output logic [LINE_W-1:0] resp_data,
  output logic [ADDR_W-1:0] resp_line_addr,
  output logic              busy,
  output logic [ADDR_W-1:0] data_requested,
  output logic [ADDR_W-1:0] where_to_write,
  output logic [LINE_W-1:0] data_to_write,
  output logic              write_to_mem,
  input  logic [LINE_W-1:0] data_returned
`ifdef MEM_REQ_STATS_EN
  ,
  output logic [15:0]       fill_count,
  output logic [15:0]       wb_count
`endif
);

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

  localparam logic [7:0] LAT_RELOAD = 8'(LATENCY - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [7:0]        r_latCnt;
  logic [ADDR_W-1:0] r_fillAddr;
  logic [ADDR_W-1:0] r_dataRequested;
  logic [ADDR_W-1:0] r_whereToWrite;
  logic [LINE_W-1:0] r_dataToWrite;
  logic [LINE_W-1:0] r_respData;
  logic [ADDR_W-1:0] r_respLineAddr;
  logic              w_latDone;
  logic              w_accept;

  assign w_latDone = (r_latCnt == 8'd0);
  assign w_accept  = (r_state == IDLE) && req_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_nextState = req_dirty ? WB : FILL;
      WB:      if (w_latDone) w_nextState = FILL;
      FILL:    if (w_latDone) w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Strobes are decoded from the state so reset drops them without waiting for a clock.
  always_comb begin
    req_ready    = (r_state == IDLE);
    busy         = (r_state != IDLE);
    resp_valid   = (r_state == RESP);
    write_to_mem = (r_state == WB) && w_latDone;
  end

  // RAM-facing address/data registers only load when their access begins, so they hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_latCnt        <= 8'd0;
      r_fillAddr      <= '0;
      r_dataRequested <= '0;
      r_whereToWrite  <= '0;
      r_dataToWrite   <= '0;
      r_respData      <= '0;
      r_respLineAddr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_latCnt   <= LAT_RELOAD;
            r_fillAddr <= req_line_addr;
            if (req_dirty) begin
              r_whereToWrite <= req_victim_addr;
              r_dataToWrite  <= req_victim_data;
            end else begin
              r_dataRequested <= req_line_addr;
            end
          end
        end
        WB: begin
          if (w_latDone) begin
            r_latCnt        <= LAT_RELOAD;
            r_dataRequested <= r_fillAddr;
          end else begin
            r_latCnt <= r_latCnt - 8'd1;
          end
        end
        FILL: begin
          if (w_latDone) begin
            r_respData     <= data_returned;
            r_respLineAddr <= r_fillAddr;
          end else begin
            r_latCnt <= r_latCnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_data      = r_respData;
  assign resp_line_addr = r_respLineAddr;
  assign data_requested = r_dataRequested;
  assign where_to_write = r_whereToWrite;
  assign data_to_write  = r_dataToWrite;

`ifdef MEM_REQ_STATS_EN
  logic [15:0] r_fillCount;
  logic [15:0] r_wbCount;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fillCount <= 16'd0;
      r_wbCount   <= 16'd0;
    end else begin
      if ((r_state == FILL) && w_latDone && (r_fillCount != 16'hFFFF))
        r_fillCount <= r_fillCount + 16'd1;
      if ((r_state == WB) && w_latDone && (r_wbCount != 16'hFFFF))
        r_wbCount <= r_wbCount + 16'd1;
    end
  end

  assign fill_count = r_fillCount;
  assign wb_count   = r_wbCount;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_line_requester.sv
// Scoreboard bench for mem_line_requester: a cycle model predicts handshake timing, queues hold expected write-backs and fills.
module tb_mem_line_requester;

  localparam int LAT = 5;
  localparam int AW  = 26;
  localparam int LW  = 128;

  localparam logic [LW-1:0] LINE_CLEAN = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [LW-1:0] LINE_2001  = 128'hCAFEF00D11223344556677889900AABB;
  localparam logic [LW-1:0] LINE_0010  = 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F;
  localparam logic [LW-1:0] LINE_DEAD  = {4{32'hDEADBEEF}};
  localparam logic [LW-1:0] LINE_A5    = {16{8'hA5}};
  localparam logic [LW-1:0] LINE_55    = {16{8'h55}};
  localparam logic [LW-1:0] LINE_77    = {16{8'h77}};

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_line_addr;
  logic          req_dirty;
  logic [AW-1:0] req_victim_addr;
  logic [LW-1:0] req_victim_data;
  logic          resp_valid;
  logic [LW-1:0] resp_data;
  logic [AW-1:0] resp_line_addr;
  logic          busy;
  logic [AW-1:0] data_requested;
  logic [AW-1:0] where_to_write;
  logic [LW-1:0] data_to_write;
  logic          write_to_mem;
  logic [LW-1:0] data_returned;

  always #5 clk = ~clk;

  mem_line_requester #(.LATENCY(LAT), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_line_addr(req_line_addr),
    .req_dirty(req_dirty), .req_victim_addr(req_victim_addr), .req_victim_data(req_victim_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_line_addr(resp_line_addr),
    .busy(busy), .data_requested(data_requested), .where_to_write(where_to_write),
    .data_to_write(data_to_write), .write_to_mem(write_to_mem), .data_returned(data_returned)
  );

  // Line RAM: combinational read, write on the rising edge while the strobe is high.
  logic [LW-1:0] ram [0:16383];
  assign data_returned = ram[data_requested[13:0]];
  always @(posedge clk) if (write_to_mem) ram[where_to_write[13:0]] <= data_to_write;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } exp_t;

  exp_t          respQ[$];
  exp_t          wbQ[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            respCycle = -1;
  int            wbCycle = -1;
  int            fillStart = -1;
  int            acceptCount = 0;
  bit            monitorOn = 1'b0;
  logic [AW-1:0] fillAddrModel = '0;
  logic [LW-1:0] stimExpData = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [LW-1:0] actual, input logic [LW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: compares handshake strobes with the cycle model, pops the scoreboard, and records accepts.
  always @(negedge clk) begin
    bit   idle;
    exp_t e;
    if (reset_n && monitorOn) begin
      idle = (cyc > respCycle);
      checkOutput("req_ready", {127'd0, req_ready}, {127'd0, idle});
      checkOutput("busy", {127'd0, busy}, {127'd0, !idle});
      checkOutput("resp_valid_timing", {127'd0, resp_valid}, {127'd0, cyc == respCycle});
      checkOutput("write_to_mem_timing", {127'd0, write_to_mem}, {127'd0, cyc == wbCycle});
      if (!idle && cyc >= fillStart && cyc < respCycle)
        checkOutput("data_requested", {102'd0, data_requested}, {102'd0, fillAddrModel});
      if (resp_valid) begin
        if (respQ.size() == 0) begin
          checkOutput("resp_unexpected", {127'd0, resp_valid}, 128'd0);
        end else begin
          e = respQ.pop_front();
          checkOutput("resp_data", resp_data, e.data);
          checkOutput("resp_line_addr", {102'd0, resp_line_addr}, {102'd0, e.addr});
        end
      end
      if (write_to_mem) begin
        if (wbQ.size() == 0) begin
          checkOutput("wb_unexpected", {127'd0, write_to_mem}, 128'd0);
        end else begin
          e = wbQ.pop_front();
          checkOutput("where_to_write", {102'd0, where_to_write}, {102'd0, e.addr});
          checkOutput("data_to_write", data_to_write, e.data);
        end
      end
      if (idle && req_valid) begin
        wbCycle       = req_dirty ? cyc + LAT : -1;
        fillStart     = cyc + 1 + (req_dirty ? LAT : 0);
        respCycle     = fillStart + LAT;
        fillAddrModel = req_line_addr;
        respQ.push_back('{addr: req_line_addr, data: stimExpData});
        if (req_dirty) wbQ.push_back('{addr: req_victim_addr, data: req_victim_data});
        acceptCount++;
      end
    end
  end

  // Presents a request and holds it until the model sees it accepted; returns just after the accept edge.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic dirty, input logic [AW-1:0] vAddr,
                               input logic [LW-1:0] vData, input logic [LW-1:0] expData);
    int start;
    start           = acceptCount;
    req_line_addr   = addr;
    req_dirty       = dirty;
    req_victim_addr = vAddr;
    req_victim_data = vData;
    stimExpData     = expData;
    req_valid       = 1'b1;
    for (int i = 0; i < 100 && acceptCount == start; i++) @(posedge clk);
    if (acceptCount == start) checkOutput("accept_timeout", 128'd0, 128'd1);
    #1;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200 && !(cyc > respCycle && respQ.size() == 0 && wbQ.size() == 0); i++)
      @(posedge clk);
    if (!(cyc > respCycle && respQ.size() == 0 && wbQ.size() == 0))
      checkOutput("idle_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic assertReset();
    monitorOn = 1'b0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    respQ.delete();
    wbQ.delete();
    respCycle = -1;
    wbCycle   = -1;
    fillStart = -1;
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    monitorOn = 1'b1;
  endtask

  initial begin
    reset_n         = 1'b0;
    req_valid       = 1'b0;
    req_line_addr   = '0;
    req_dirty       = 1'b0;
    req_victim_addr = '0;
    req_victim_data = '0;
    for (int i = 0; i < 16384; i++) ram[i] = '0;
    ram[14'h0400] = LINE_CLEAN;
    ram[14'h2001] = LINE_2001;
    ram[14'h0010] = LINE_0010;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    checkOutput("rst_resp_valid", {127'd0, resp_valid}, 128'd0);
    checkOutput("rst_write_to_mem", {127'd0, write_to_mem}, 128'd0);
    checkOutput("rst_busy", {127'd0, busy}, 128'd0);
    checkOutput("rst_req_ready", {127'd0, req_ready}, 128'd1);
    checkOutput("rst_data_requested", {102'd0, data_requested}, 128'd0);
    checkOutput("rst_where_to_write", {102'd0, where_to_write}, 128'd0);
    checkOutput("rst_data_to_write", data_to_write, 128'd0);
    checkOutput("rst_resp_data", resp_data, 128'd0);
    checkOutput("rst_resp_line_addr", {102'd0, resp_line_addr}, 128'd0);
    @(posedge clk);
    #1 monitorOn = 1'b1;

    $display("[TB] clean miss");
    applyStimulus(26'h0000400, 1'b0, 26'h0, '0, LINE_CLEAN);
    req_valid = 1'b0;
    waitIdle();

    $display("[TB] dirty miss");
    applyStimulus(26'h0002001, 1'b1, 26'h0002000, LINE_DEAD, LINE_2001);
    req_valid = 1'b0;
    waitIdle();
    checkOutput("ram_wb_line", ram[14'h2000], LINE_DEAD);
    checkOutput("resp_data_hold", resp_data, LINE_2001);
    checkOutput("resp_addr_hold", {102'd0, resp_line_addr}, 128'h2001);

    $display("[TB] read back written victim");
    applyStimulus(26'h0002000, 1'b0, 26'h0, '0, LINE_DEAD);
    req_valid = 1'b0;
    waitIdle();

    $display("[TB] victim equals fill address");
    applyStimulus(26'h0000010, 1'b1, 26'h0000010, LINE_A5, LINE_A5);
    req_valid = 1'b0;
    waitIdle();

    $display("[TB] back-to-back with req_valid held");
    applyStimulus(26'h0000400, 1'b0, 26'h0, '0, LINE_CLEAN);
    applyStimulus(26'h0002001, 1'b1, 26'h0003000, LINE_55, LINE_2001);
    req_valid = 1'b0;
    waitIdle();
    checkOutput("ram_wb_3000", ram[14'h3000], LINE_55);

    $display("[TB] reset during fill");
    applyStimulus(26'h0000400, 1'b0, 26'h0, '0, LINE_CLEAN);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    assertReset();
    #1;
    checkOutput("rstfill_resp_valid", {127'd0, resp_valid}, 128'd0);
    checkOutput("rstfill_write_to_mem", {127'd0, write_to_mem}, 128'd0);
    checkOutput("rstfill_busy", {127'd0, busy}, 128'd0);
    checkOutput("rstfill_req_ready", {127'd0, req_ready}, 128'd1);
    checkOutput("rstfill_resp_data", resp_data, 128'd0);
    releaseReset();
    repeat (20) @(posedge clk);
    #1;

    $display("[TB] reset during write strobe");
    applyStimulus(26'h0002001, 1'b1, 26'h0002000, LINE_77, LINE_2001);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("wb_strobe_before_reset", {127'd0, write_to_mem}, 128'd1);
    assertReset();
    #1;
    checkOutput("wb_strobe_after_reset", {127'd0, write_to_mem}, 128'd0);
    releaseReset();
    repeat (20) @(posedge clk);
    #1;
    checkOutput("ram_2000_untouched", ram[14'h2000], LINE_DEAD);

    $display("[TB] recovery miss");
    applyStimulus(26'h0000010, 1'b0, 26'h0, '0, LINE_A5);
    req_valid = 1'b0;
    waitIdle();

    checkOutput("queues_drained", 128'(respQ.size() + wbQ.size()), 128'd0);
    monitorOn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
